// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Bits needed to hold every count from 0 up to and including the limit.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_boot_checker.sv
// Reads the sysid slave (ID word, then timestamp word) over Avalon-MM after
// reset or on request, and reports whether the FPGA image matches the build.
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5599_7155,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int             CW        = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TMO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          reset_q;
  logic          launch;

  assign cnt_inc = cnt + CW'(1);

  // The first cycle after reset releases behaves like a start pulse.
  always_ff @(posedge clock) reset_q <= reset;

  assign launch = start | (AUTO_START & reset_q);

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked block
    // and takes priority over every other assignment on the same edge.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (launch) begin
            state       <= REQ_ID;
            cnt         <= '0;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end

        REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
          // NOTE: non-blocking assignments let a later branch override this
          // default increment; the last one scheduled on the edge wins.
          cnt <= cnt_inc;
          if (state == WAIT_ID && avm_readdatavalid) begin
            id_value    <= avm_readdata;
            state       <= REQ_TS;
            cnt         <= '0;
            avm_read    <= 1'b1;
            avm_address <= ADDR_TS;
          end else if (state == WAIT_TS && avm_readdatavalid) begin
            ts_value <= avm_readdata;
            state    <= CHECK;
          end else if (cnt_inc == TMO_LIMIT) begin
            // A capture on the limit cycle was already taken above.
            state    <= DONE;
            avm_read <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end else if (state == REQ_ID && !avm_waitrequest) begin
            state    <= WAIT_ID;
            avm_read <= 1'b0;
          end else if (state == REQ_TS && !avm_waitrequest) begin
            state    <= WAIT_TS;
            avm_read <= 1'b0;
          end
        end

        CHECK: begin
          id_mismatch <= (id_value != EXPECTED_ID);
          ts_mismatch <= (ts_value != EXPECTED_TS);
          pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomised self-checking bench for sysid_boot_checker with a behavioural
// Avalon sysid slave and an arithmetic model of the expected outcome.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h5599_7155;
  localparam int          TMO    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;
  logic [5:0]  flags;

  assign flags = {busy, done, pass, id_mismatch, ts_mismatch, timeout};

  always #5 clock = ~clock;

  sysid_boot_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(TMO),
    .AUTO_START    (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .id_mismatch      (id_mismatch),
    .ts_mismatch      (ts_mismatch),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  // Slave configuration, written only by the main sequence.
  int          cfg_wait    = 0;
  int          cfg_lat     = 1;
  logic [31:0] cfg_id      = EXP_ID;
  logic [31:0] cfg_ts      = EXP_TS;
  bit          cfg_respond = 1'b1;
  int          inject_cnt  = 0;
  logic [31:0] inject_data = 32'h0;

  // Slave observations, written only by the slave process.
  int          reads    = 0;
  int          stab_err = 0;
  logic [1:0]  addr_hist = 2'b00;

  // Behavioural sysid slave: wait states per request, fixed read latency.
  initial begin
    bit   acc_q = 1'b0, stall_q = 1'b0, pend = 1'b0;
    logic acc_addr_q = 1'b0, stall_addr_q = 1'b0, pend_addr = 1'b0;
    int   wait_left = 0, pend_left = 0, inject_seen = 0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_q && !(avm_read === 1'b1 && avm_address === stall_addr_q)) stab_err++;
      if (acc_q) begin
        reads++;
        addr_hist = {addr_hist[0], acc_addr_q};
        pend      = 1'b1;
        pend_left = cfg_lat;
        pend_addr = acc_addr_q;
      end
      avm_readdatavalid = 1'b0;
      if (pend) begin
        pend_left--;
        if (pend_left <= 0) begin
          pend = 1'b0;
          if (cfg_respond) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_addr ? cfg_ts : cfg_id;
          end
        end
      end
      if (inject_seen != inject_cnt) begin
        inject_seen       = inject_cnt;
        avm_readdatavalid = 1'b1;
        avm_readdata      = inject_data;
      end
      if (avm_read === 1'b1) begin
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end else begin
        avm_waitrequest = 1'b0;
        wait_left       = cfg_wait;
      end
      acc_q        = (avm_read === 1'b1) && !avm_waitrequest;
      acc_addr_q   = avm_address;
      stall_q      = (avm_read === 1'b1) && avm_waitrequest;
      stall_addr_q = avm_address;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0 (launch requested this cycle); returns the cycle in
  // which done is first seen, counting the launch request cycle as 0.
  task automatic wait_done(input string tag, input bit poke, output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      start = poke && (cyc == 3);
      if (cyc == 1) begin
        check({tag, "/launch_flags"}, flags, 6'b100000);
        check({tag, "/launch_id"}, id_value, 32'h0);
        check({tag, "/launch_ts"}, ts_value, 32'h0);
      end
    end while (!done && cyc < 200);
    start = 1'b0;
    if (cyc >= 200) check({tag, "/done_seen"}, done, 1'b1);
  endtask

  // Reference model: each transaction costs (wait + 1) request cycles plus
  // latency response cycles; over TMO cycles means the ID read gives up.
  task automatic verify(input string tag, input int w, input int l,
                        input logic [31:0] id, input logic [31:0] ts,
                        input bit respond, input int cyc, input int reads0);
    int   t;
    bit   tmo, idm, tsm;
    t   = w + 1 + l;
    tmo = !respond || (t > TMO);
    idm = !tmo && (id != EXP_ID);
    tsm = !tmo && (ts != EXP_TS);
    check({tag, "/cycles"}, cyc, tmo ? (TMO + 1) : (2 * t + 2));
    check({tag, "/flags"}, flags, {1'b0, 1'b1, !tmo && !idm && !tsm, idm, tsm, tmo});
    check({tag, "/id_value"}, id_value, tmo ? 32'h0 : id);
    check({tag, "/ts_value"}, ts_value, tmo ? 32'h0 : ts);
    check({tag, "/avm_read"}, avm_read, 1'b0);
    check({tag, "/reads"}, reads - reads0, tmo ? 1 : 2);
    if (!tmo) check({tag, "/addr_order"}, addr_hist, 2'b01);
    check({tag, "/stable"}, stab_err, 0);
  endtask

  task automatic run(input string tag, input int w, input int l,
                     input logic [31:0] id, input logic [31:0] ts,
                     input bit respond, input bit poke);
    int cyc, reads0;
    cfg_wait    = w;
    cfg_lat     = l;
    cfg_id      = id;
    cfg_ts      = ts;
    cfg_respond = respond;
    repeat (2) @(negedge clock);
    reads0 = reads;
    start  = 1'b1;
    wait_done(tag, poke, cyc);
    verify(tag, w, l, id, ts, respond, cyc, reads0);
  endtask

  initial begin
    int cyc, reads0, w, l;
    logic [31:0] id, ts;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("reset/outputs", {flags, avm_read, avm_address}, 8'h00);
    check("reset/id_value", id_value, 32'h0);
    check("reset/ts_value", ts_value, 32'h0);

    // Automatic check on release of reset: cycle 0 is the first unreset cycle.
    reads0 = reads;
    reset  = 1'b0;
    wait_done("auto", 1'b0, cyc);
    verify("auto", 0, 1, EXP_ID, EXP_TS, 1'b1, cyc, reads0);

    run("ts_mismatch", 0, 1, EXP_ID, 32'h5599_7156, 1'b1, 1'b0);
    run("wait3", 3, 1, EXP_ID, EXP_TS, 1'b1, 1'b0);
    run("busy_start", 1, 2, EXP_ID, EXP_TS, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      w  = $urandom_range(0, 4);
      l  = $urandom_range(1, 4);
      id = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      ts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      run($sformatf("rand%0d", i), w, l, id, ts, 1'b1, 1'b0);
    end

    run("limit_exact", 7, 8, EXP_ID, EXP_TS, 1'b1, 1'b0);
    run("limit_over", 7, 9, EXP_ID, EXP_TS, 1'b1, 1'b0);
    run("no_response", 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);

    // A response arriving after the timeout must not be captured.
    inject_data = 32'hDEAD_BEEF;
    inject_cnt++;
    repeat (3) @(negedge clock);
    check("late_rdv/id_value", id_value, 32'h0);
    check("late_rdv/ts_value", ts_value, 32'h0);
    check("late_rdv/flags", flags, 6'b010001);

    // Reset while waiting for the timestamp response.
    cfg_wait    = 0;
    cfg_lat     = 4;
    cfg_id      = EXP_ID;
    cfg_ts      = EXP_TS;
    cfg_respond = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    check("mid_reset/in_wait_ts", {busy, avm_read, avm_address}, 3'b101);
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset/outputs", {flags, avm_read, avm_address}, 8'h00);
    check("mid_reset/values", {id_value, ts_value}, 64'h0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    run("after_reset", 0, 4, EXP_ID, EXP_TS, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
